image_mem_streamer: RTL and testbench
=====================================

// Module: image_mem_streamer
// PURPOSE
//  Reads an 8-bit image frame from the single-port on-chip image RAM and emits it as a pixel stream.
//  - RAM: 64K x 8, address registered, q unregistered, so read latency is 1 clk.
//  - Stream: valid/ready, raster order, carries sop/eol/eop markers.
//  - Sits directly upstream of the pixel-processing pipeline; drives the RAM's read port.
//  - Started by a start pulse from the Nios control registers.
// PARAMETERS
//  ADDR_W      16  RAM address width; addresses wrap modulo 2^ADDR_W
//  PIX_W       8   pixel/readdata width
//  DIM_W       16  width of the img_width/img_height inputs
//  FIFO_DEPTH  4   return-data buffer entries; must be >=3 for 1 pixel/clk sustained
// PORTS
//  clk            in   1       system clock; only clock in the block
//  reset_n        in   1       asynchronous, active-low reset
//  start          in   1       1-clk pulse; begin frame (ignored while busy)
//  base_addr      in   ADDR_W  RAM address of pixel (0,0); sampled on accepted start
//  img_width      in   DIM_W   pixels per line; sampled on accepted start
//  img_height     in   DIM_W   lines per frame; sampled on accepted start
//  abort          in   1       synchronous frame cancel
//  busy           out  1       frame in progress
//  done           out  1       1-clk pulse after the last pixel is accepted downstream
//  mem_address    out  ADDR_W  RAM address
//  mem_chipselect out  1       read request qualifier
//  mem_write      out  1       tied 0
//  mem_clken      out  1       tied 1
//  mem_readdata   in   PIX_W   RAM q; valid 1 clk after the address is presented
//  st_data        out  PIX_W   pixel
//  st_valid       out  1       st_data valid
//  st_ready       in   1       sink accepts when st_valid&st_ready
//  st_sop         out  1       first pixel of frame
//  st_eol         out  1       last pixel of each line
//  st_eop         out  1       last pixel of frame
// BEHAVIOUR
//  Reset values
//   - All outputs 0, except mem_clken=1; mem_address=0.
//   - FSM in IDLE; FIFO empty; counters 0.
//  FSM states: IDLE, FETCH, DRAIN, DONE.
//   - IDLE -> FETCH on start when width!=0 and height!=0.
//   - IDLE -> DONE on start when width==0 or height==0; done pulses with no reads and no stream beats.
//   - FETCH -> DRAIN after issuing read W*H-1.
//   - DRAIN -> DONE when the FIFO is empty, nothing is in flight, and the last beat is accepted.
//   - DONE -> IDLE unconditionally; done=1 only in DONE.
//   - busy=1 in FETCH and DRAIN.
//  Read issue
//   - One read per clk in FETCH while (fifo_count + inflight) < FIFO_DEPTH; inflight is 0 or 1.
//   - Issue asserts mem_chipselect; mem_address = base + linear index, truncated to ADDR_W (wraps FFFF->0000).
//   - Returned data (1 clk later) is pushed into the FIFO with the sop/eol/eop flags computed at issue.
//   - Line (x) and frame (y) counters are DIM_W wide; eol when x==W-1; eop when x==W-1 && y==H-1.
//  Stream
//   - st_* are driven from the FIFO head (registered).
//   - Latency: start edge N -> first address in clk N+1 -> data in N+2 -> st_valid in N+3.
//   - st_valid, once asserted, holds with stable data/flags until accepted (no retraction).
//   - With st_ready held high: one beat per clk.
//  Boundaries
//   - start while busy: ignored; latched parameters unchanged.
//   - abort (any state): next clk go IDLE; FIFO flushed; in-flight data discarded; st_valid=0; no done pulse.
//   - abort and start in the same clk while busy: abort wins.
//   - reset_n low mid-frame: immediate return to reset values; nothing resumes.
//   - FIFO never overflows by construction. Verification asserts this; the block adds no overflow logic.
// STRUCTURE
//  - Package image_stream_pkg: ADDR_W/PIX_W/DIM_W defaults and the FSM state enum.
//    Also the FIFO entry struct {data, sop, eol, eop}.
//  - Sub-module image_stream_fifo: sync FIFO, FIFO_DEPTH x (PIX_W+3); push/pop/count/flush.
//  - Top holds the FSM, counters, credit logic and RAM interface.
// TESTING
//  1. base=0x0100, 4x2, ready=1: addresses 0x0100..0x0107; 8 beats, one per clk from N+3.
//     sop on beat 0; eol on beats 3 and 7; eop on beat 7; done 1 clk after beat 7.
//  2. Same frame, ready toggling 1-0-1-0: data matches RAM in order; st_data/flags stable while stalled.
//     fifo_count never > 4; 8 beats, then done.
//  3. base=0xFFFE, 4x1: addresses FFFE, FFFF, 0000, 0001; eop on beat 3.
//  4. width=0, height=5: done pulses; zero chipselects; zero beats; busy stays 0.
//  5. 16x16 frame: pulse start again mid-frame -> ignored; 256 beats total.
//     Repeat and assert abort at beat 100 -> st_valid=0 next clk, no done; a following start yields a clean frame.
//  6. reset_n low at beat 5 -> all outputs at reset values asynchronously.
//     After release, a new start streams from sop correctly.

Source files
------------

// File: rtl/image_stream_pkg.sv
// Shared widths, FSM state encoding and return-buffer entry layout for the
// image RAM streamer.
package image_stream_pkg;

    localparam int ADDR_W_DFLT     = 16;
    localparam int PIX_W_DFLT      = 8;
    localparam int DIM_W_DFLT      = 16;
    localparam int FIFO_DEPTH_DFLT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PIX_W_DFLT-1:0] data;
        logic                  sop;
        logic                  eol;
        logic                  eop;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/image_stream_fifo.sv
// Small synchronous FIFO holding returned pixels with their stream markers.
// Callers guarantee no push when full and no pop when empty; flush has priority.
module image_stream_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 11,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign empty    = (r_count == '0);

endmodule

// File: rtl/image_mem_streamer.sv
// Reads a W x H 8-bit frame from the image RAM (1-clk read latency) and emits
// it as a raster valid/ready stream with sop/eol/eop markers.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; parameters latched on an accepted start
//   ST_FETCH | issuing reads while buffer credit allows
//   ST_DRAIN | all reads issued; emptying buffer and output register
//   ST_DONE  | one-clk done pulse, then back to idle
module image_mem_streamer
    import image_stream_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DFLT,
    parameter int PIX_W      = PIX_W_DFLT,
    parameter int DIM_W      = DIM_W_DFLT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [PIX_W-1:0]  mem_readdata,
    output logic [PIX_W-1:0]  st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eol,
    output logic              st_eop
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_base, r_idx;
    logic [DIM_W-1:0]  r_width, r_height, r_x, r_y;
    logic              r_inflight, r_if_sop, r_if_eol, r_if_eop;
    fifo_entry_t       r_st;
    logic              r_st_valid;

    logic              w_start_ok, w_zero_dim, w_x_last, w_y_last, w_issue;
    logic              w_push, w_pop, w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W:0]    w_credit_used;
    fifo_entry_t       w_push_entry, w_head;

    assign w_zero_dim    = (img_width == '0) || (img_height == '0);
    assign w_start_ok    = (r_state == ST_IDLE) && start && !abort;
    assign w_x_last      = (r_x == r_width - DIM_W'(1));
    assign w_y_last      = (r_y == r_height - DIM_W'(1));
    // A read only goes out if its data is guaranteed a buffer slot.
    assign w_credit_used = {1'b0, w_fifo_count} + (CNT_W + 1)'(r_inflight);
    assign w_issue       = (r_state == ST_FETCH) && !abort &&
                           (w_credit_used < (CNT_W + 1)'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = w_zero_dim ? ST_DONE : ST_FETCH;
            ST_FETCH: if (w_issue && w_x_last && w_y_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_fifo_empty && !r_inflight && r_st_valid && st_ready && r_st.eop)
                          w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base     <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_idx      <= '0;
            r_inflight <= 1'b0;
            r_if_sop   <= 1'b0;
            r_if_eol   <= 1'b0;
            r_if_eop   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_start_ok) begin
                r_base   <= base_addr;
                r_width  <= img_width;
                r_height <= img_height;
                r_x      <= '0;
                r_y      <= '0;
                r_idx    <= '0;
            end else if (w_issue) begin
                r_if_sop <= (r_x == '0) && (r_y == '0);
                r_if_eol <= w_x_last;
                r_if_eop <= w_x_last && w_y_last;
                r_idx    <= r_idx + ADDR_W'(1);
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= r_y + DIM_W'(1);
                end else begin
                    r_x <= r_x + DIM_W'(1);
                end
            end
        end
    end

    assign w_push_entry = '{data: mem_readdata, sop: r_if_sop, eol: r_if_eol, eop: r_if_eop};
    assign w_push       = r_inflight && !abort;
    assign w_pop        = !w_fifo_empty && !abort && (!r_st_valid || st_ready);

    image_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (abort),
        .pop_data  (w_head),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty)
    );

    // Output register refills from the buffer head in the same clk a beat is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_st_valid <= 1'b0;
            r_st       <= '0;
        end else if (abort) begin
            r_st_valid <= 1'b0;
        end else if (w_pop) begin
            r_st_valid <= 1'b1;
            r_st       <= w_head;
        end else if (st_ready) begin
            r_st_valid <= 1'b0;
        end
    end

    assign busy           = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign done           = (r_state == ST_DONE);
    assign mem_chipselect = w_issue;
    assign mem_address    = w_issue ? (r_base + r_idx) : '0;
    assign mem_write      = 1'b0;
    assign mem_clken      = 1'b1;
    assign st_valid       = r_st_valid;
    assign st_data        = r_st.data;
    assign st_sop         = r_st.sop;
    assign st_eol         = r_st.eol;
    assign st_eop         = r_st.eop;

endmodule

// File: tb/tb_image_mem_streamer.sv
// Directed and randomized frames against a raster-order reference built from
// the RAM contents; a negedge monitor collects beats, addresses and pulses.
module tb_image_mem_streamer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        st_ready = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] img_width = '0;
    logic [15:0] img_height = '0;
    logic        busy, done, mem_chipselect, mem_write, mem_clken;
    logic [15:0] mem_address;
    logic [7:0]  mem_readdata, st_data;
    logic        st_valid, st_sop, st_eol, st_eop;

    image_mem_streamer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .img_width      (img_width),
        .img_height     (img_height),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eol         (st_eol),
        .st_eop         (st_eop)
    );

    always #5 clk = ~clk;

    // RAM model: registered address, unregistered q.
    logic [7:0] ram [65536];
    logic [7:0] rd_q = '0;
    always @(posedge clk) rd_q <= ram[mem_address];
    assign mem_readdata = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [15:0] addr_q[$];
    logic [10:0] beat_q[$];
    int          beat_cyc_q[$];
    int          first_valid_cyc = -1;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          busy_cnt = 0;
    int          stall_err = 0;
    int          ovf_err = 0;
    logic        prev_stall = 1'b0;
    logic [10:0] prev_beat = '0;

    always @(negedge clk) begin
        if (mem_chipselect) addr_q.push_back(mem_address);
        if (st_valid && st_ready) begin
            beat_q.push_back({st_data, st_sop, st_eol, st_eop});
            beat_cyc_q.push_back(cyc);
        end
        if (st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (prev_stall && !(st_valid && ({st_data, st_sop, st_eol, st_eop} == prev_beat)))
            stall_err++;
        if (dut.w_fifo_count > 3'd4) ovf_err++;
        prev_stall = st_valid && !st_ready && !abort && reset_n;
        prev_beat  = {st_data, st_sop, st_eol, st_eop};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 32'({busy, done, mem_chipselect, mem_write, mem_clken,
                                  st_valid, st_sop, st_eol, st_eop}), 32'b0_0000_1000_0);
        check({tag, "_addr"}, 32'(mem_address), 32'h0);
        check({tag, "_data"}, 32'(st_data), 32'h0);
    endtask

    task automatic run_frame(input logic [15:0] b, input int w, input int h, input int mode,
                             input int restart_at, input int abort_at, input int reset_at,
                             input string tag);
        logic [15:0] ea[$];
        logic [10:0] eb[$];
        logic [15:0] a;
        int          limit;
        int          start_cyc;
        int          mism;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                a = b + 16'(y * w + x);
                ea.push_back(a);
                eb.push_back({ram[a], (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1)});
            end
        end
        addr_q.delete();
        beat_q.delete();
        beat_cyc_q.delete();
        first_valid_cyc = -1;
        done_cnt = 0;
        done_cyc = -1;
        busy_cnt = 0;
        stall_err = 0;
        ovf_err = 0;
        prev_stall = 1'b0;

        base_addr = b;
        img_width = 16'(w);
        img_height = 16'(h);
        st_ready = (mode != 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        limit = 6 * w * h + 20;
        for (int k = 0; k < limit && done_cnt == 0; k++) begin
            case (mode)
                0:       st_ready = 1'b1;
                1:       st_ready = (k % 2 == 1);
                default: st_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (k == restart_at) begin
                start = 1'b1;
                base_addr = 16'hBEEF;
                img_width = 16'd3;
                img_height = 16'd7;
            end
            if (abort_at >= 0 && beat_q.size() >= abort_at) begin
                abort = 1'b1;
                start = 1'b1;
                tick();
                abort = 1'b0;
                start = 1'b0;
                check({tag, "_abort_valid"}, 32'(st_valid), 32'h0);
                check({tag, "_abort_busy"}, 32'(busy), 32'h0);
                repeat (10) tick();
                check({tag, "_abort_no_done"}, 32'(done_cnt), 32'h0);
                check({tag, "_abort_idle"}, 32'({busy, st_valid, mem_chipselect}), 32'h0);
                return;
            end
            if (reset_at >= 0 && beat_q.size() >= reset_at) begin
                #2 reset_n = 1'b0;
                #1;
                check_reset_outputs({tag, "_async_rst"});
                tick();
                tick();
                reset_n = 1'b1;
                repeat (3) tick();
                check({tag, "_rst_stays_idle"}, 32'({busy, done, st_valid, mem_chipselect}), 32'h0);
                return;
            end
            tick();
            start = 1'b0;
        end
        repeat (4) tick();
        check({tag, "_done_once"}, 32'(done_cnt), 32'h1);
        check({tag, "_beat_count"}, 32'(beat_q.size()), 32'(eb.size()));
        check({tag, "_read_count"}, 32'(addr_q.size()), 32'(ea.size()));
        mism = 0;
        for (int i = 0; i < eb.size(); i++)
            if (i >= beat_q.size() || beat_q[i] !== eb[i]) mism++;
        check({tag, "_beat_mismatches"}, 32'(mism), 32'h0);
        mism = 0;
        for (int i = 0; i < ea.size(); i++)
            if (i >= addr_q.size() || addr_q[i] !== ea[i]) mism++;
        check({tag, "_addr_mismatches"}, 32'(mism), 32'h0);
        check({tag, "_stall_stable"}, 32'(stall_err), 32'h0);
        check({tag, "_no_overflow"}, 32'(ovf_err), 32'h0);
        if (w * h > 0) begin
            check({tag, "_first_valid_lat"}, 32'(first_valid_cyc - start_cyc), 32'd3);
            if (beat_cyc_q.size() > 0)
                check({tag, "_done_after_last"}, 32'(done_cyc - beat_cyc_q[$]), 32'd1);
            if (mode == 0 && beat_cyc_q.size() > 0)
                check({tag, "_one_per_clk"}, 32'(beat_cyc_q[$] - beat_cyc_q[0]), 32'(w * h - 1));
        end else begin
            check({tag, "_never_busy"}, 32'(busy_cnt), 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        run_frame(16'h0100, 4, 2, 0, -1, -1, -1, "t1_basic");
        run_frame(16'h0100, 4, 2, 1, -1, -1, -1, "t2_toggle_ready");
        run_frame(16'hFFFE, 4, 1, 0, -1, -1, -1, "t3_wrap");
        run_frame(16'h0000, 0, 5, 0, -1, -1, -1, "t4_zero_width");
        run_frame(16'h0040, 3, 0, 0, -1, -1, -1, "t4b_zero_height");
        run_frame(16'h2000, 16, 16, 0, 40, -1, -1, "t5_restart_ignored");
        run_frame(16'h3000, 16, 16, 2, -1, 100, -1, "t5_abort");
        run_frame(16'h4000, 16, 16, 0, -1, -1, -1, "t5_after_abort");
        run_frame(16'h5000, 4, 4, 0, -1, -1, 5, "t6_reset");
        run_frame(16'h5000, 4, 4, 0, -1, -1, -1, "t6_after_reset");
        for (int r = 0; r < 6; r++) begin
            run_frame(16'($urandom), int'($urandom_range(1, 9)), int'($urandom_range(1, 6)), 2,
                      -1, -1, -1, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
